// File: rtl/xbi_pkg.sv
// Shared XBI glue types: FSM encoding, width defaults, packed-count slicing.
package xbi_pkg;

  localparam int XBI_DW = 16;
  localparam int XBI_OW = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COPY  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_GAP   = 2'd3
  } xb_state_e;

  // Extract the pw-bit count of VC v from a flat per-VC vector (<= 64 bits).
  function automatic logic [31:0] pkt_cnt_at(input logic [63:0] flat, input int v, input int pw);
    logic [63:0] sh;
    sh = (flat >> (v * pw)) & ((64'd1 << pw) - 64'd1);
    return sh[31:0];
  endfunction

endpackage

// File: rtl/xbglue_rr_arb.sv
// Round-robin arbiter: first requester after the pointer wins; the pointer
// moves to the winner only when the caller commits the grant.
module xbglue_rr_arb #(
  parameter int NVC = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NVC-1:0] req,
  input  logic           en,
  output logic [NVC-1:0] gnt
);
  localparam int PTRW = (NVC > 1) ? $clog2(NVC) : 1;

  logic [PTRW-1:0] ptr_q, gidx;

  // Scan from farthest to nearest so the nearest requester after ptr wins.
  always_comb begin
    gnt  = '0;
    gidx = ptr_q;
    for (int i = NVC; i >= 1; i--) begin
      if (req[(int'(ptr_q) + i) % NVC]) begin
        gnt = '0;
        gnt[(int'(ptr_q) + i) % NVC] = 1'b1;
        gidx = PTRW'((int'(ptr_q) + i) % NVC);
      end
    end
  end

  // Pointer starts at the last VC so VC0 wins the first arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= PTRW'(NVC - 1);
    else if (en && |req) ptr_q <= gidx;
  end

endmodule

// File: rtl/xbglue_rr.sv
// Point-to-point XBI packet mover: picks a VC round-robin, reads a whole
// packet from the source port and replays it into the destination port.
module xbglue_rr
  import xbi_pkg::*;
#(
  parameter int NVC       = 3,
  parameter int DW        = XBI_DW,
  parameter int OW        = XBI_OW,
  parameter int PW        = 3,
  parameter int RD_LAT    = 2,
  parameter int SIZE_WORD = 3,
  parameter int LEN_ADJ   = 6,
  parameter int MIN_PKTS  = 2,
  parameter int GAP_CYC   = 2
) (
  input  logic              clk_xbar,
  input  logic              rst_xbar_n,
  output logic [NVC-1:0]    o_src_deq,
  output logic [OW-1:0]     o_src_offset,
  output logic              o_src_eop,
  input  logic [DW-1:0]     i_src_data,
  input  logic [NVC-1:0]    i_src_empty,
  output logic [NVC-1:0]    o_dst_enq,
  output logic [OW-1:0]     o_dst_offset,
  output logic [DW-1:0]     o_dst_data,
  output logic              o_dst_eop,
  input  logic [NVC-1:0]    i_dst_full,
  input  logic [NVC*PW-1:0] i_dst_packets,
  output logic              o_busy,
  output logic [15:0]       o_pkt_cnt,
  output logic              o_err
);

  localparam int GW = $clog2(GAP_CYC + 2);

  // The size word must come back before the dequeue counter can reach the
  // smallest possible last offset; otherwise the end of packet is missed.
  if (SIZE_WORD + RD_LAT >= LEN_ADJ) begin : g_chk_lat
    $fatal(1, "xbglue_rr: SIZE_WORD+RD_LAT must be < LEN_ADJ");
  end
  if (RD_LAT < 1 || DW < OW || NVC * PW > 64) begin : g_chk_w
    $fatal(1, "xbglue_rr: unsupported width/latency parameters");
  end

  xb_state_e state_q, state_d;

  logic [NVC-1:0]        empty_q;
  logic [NVC*PW-1:0]     pkts_q;
  logic [NVC-1:0]        elig, arb_gnt, gnt_q;
  logic                  arb_en;
  logic [OW-1:0]         deq_cnt, last_q, last_eff;
  logic [RD_LAT:0]       vld_pipe;
  logic [RD_LAT:0][OW-1:0] off_pipe;
  logic                  cap, len_ovf, ret_last;
  logic [OW:0]           len_sum;
  logic [GW-1:0]         gap_cnt;

  for (genvar v = 0; v < NVC; v++) begin : g_elig
    assign elig[v] = ~empty_q[v] &
                     (pkt_cnt_at(64'(pkts_q), v, PW) >= 32'(MIN_PKTS));
  end

  xbglue_rr_arb #(.NVC(NVC)) u_arb (
    .clk   (clk_xbar),
    .rst_n (rst_xbar_n),
    .req   (elig),
    .en    (arb_en),
    .gnt   (arb_gnt)
  );

  // Length capture: the size word is on i_src_data when its offset leaves
  // the pipe; last_eff forwards the new value into this cycle's compares.
  always_comb begin
    cap      = vld_pipe[RD_LAT] && (off_pipe[RD_LAT] == OW'(SIZE_WORD));
    len_sum  = {1'b0, i_src_data[OW-1:0]} + (OW+1)'(LEN_ADJ);
    len_ovf  = len_sum[OW];
    last_eff = last_q;
    if (cap) last_eff = len_ovf ? '1 : len_sum[OW-1:0];
    ret_last = vld_pipe[RD_LAT] && (off_pipe[RD_LAT] == last_eff);
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    arb_en  = 1'b0;
    case (state_q)
      ST_IDLE: if (|elig) begin
        arb_en  = 1'b1;
        state_d = ST_COPY;
      end
      ST_COPY:  if (deq_cnt == last_eff) state_d = ST_DRAIN;
      ST_DRAIN: if (o_dst_eop) state_d = ST_GAP;
      ST_GAP:   if (32'(gap_cnt) + 32'd1 >= 32'(GAP_CYC)) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign o_busy = (state_q != ST_IDLE);

  // State, dequeue side, return pipe, enqueue side and status registers.
  always_ff @(posedge clk_xbar or negedge rst_xbar_n) begin
    if (!rst_xbar_n) begin
      state_q      <= ST_IDLE;
      empty_q      <= '0;
      pkts_q       <= '0;
      gnt_q        <= '0;
      deq_cnt      <= '0;
      last_q       <= '1;
      vld_pipe     <= '0;
      off_pipe     <= '0;
      gap_cnt      <= '0;
      o_src_deq    <= '0;
      o_src_offset <= '0;
      o_src_eop    <= 1'b0;
      o_dst_enq    <= '0;
      o_dst_offset <= '0;
      o_dst_data   <= '0;
      o_dst_eop    <= 1'b0;
      o_pkt_cnt    <= '0;
      o_err        <= 1'b0;
    end else begin
      state_q <= state_d;
      empty_q <= i_src_empty;
      pkts_q  <= i_dst_packets;

      if (arb_en) begin
        gnt_q   <= arb_gnt;
        deq_cnt <= '0;
        last_q  <= '1;
      end

      o_src_deq <= '0;
      o_src_eop <= 1'b0;
      if (state_q == ST_COPY) begin
        o_src_deq    <= gnt_q;
        o_src_offset <= deq_cnt;
        o_src_eop    <= (deq_cnt == last_eff);
        deq_cnt      <= deq_cnt + 1'b1;
      end

      if (cap) last_q <= last_eff;

      vld_pipe[0] <= (state_q == ST_COPY);
      off_pipe[0] <= deq_cnt;
      for (int i = 1; i <= RD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        off_pipe[i] <= off_pipe[i-1];
      end

      o_dst_enq <= '0;
      o_dst_eop <= 1'b0;
      if (vld_pipe[RD_LAT]) begin
        o_dst_enq    <= gnt_q;
        o_dst_offset <= off_pipe[RD_LAT];
        o_dst_data   <= i_src_data;
        o_dst_eop    <= ret_last;
      end

      gap_cnt <= (state_q == ST_GAP) ? gap_cnt + 1'b1 : '0;

      if (state_q == ST_DRAIN && o_dst_eop) o_pkt_cnt <= o_pkt_cnt + 16'd1;

      if ((cap && len_ovf) || |(o_dst_enq & i_dst_full)) o_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_xbglue_rr.sv
// Directed bench for xbglue_rr: a source memory model answers reads, a
// monitor scoreboards every dequeue against the expected enqueue.
module tb_xbglue_rr;

  localparam int NVC = 3, DW = 16, OW = 6, PW = 3, RD_LAT = 2;
  localparam int SIZE_WORD = 3, LEN_ADJ = 6, GAP_CYC = 2;

  logic              clk_xbar, rst_xbar_n;
  logic [NVC-1:0]    o_src_deq, i_src_empty, o_dst_enq, i_dst_full;
  logic [OW-1:0]     o_src_offset, o_dst_offset;
  logic              o_src_eop, o_dst_eop, o_busy, o_err;
  logic [DW-1:0]     i_src_data, o_dst_data;
  logic [NVC*PW-1:0] i_dst_packets;
  logic [15:0]       o_pkt_cnt;

  xbglue_rr dut (
    .clk_xbar(clk_xbar), .rst_xbar_n(rst_xbar_n),
    .o_src_deq(o_src_deq), .o_src_offset(o_src_offset), .o_src_eop(o_src_eop),
    .i_src_data(i_src_data), .i_src_empty(i_src_empty),
    .o_dst_enq(o_dst_enq), .o_dst_offset(o_dst_offset), .o_dst_data(o_dst_data),
    .o_dst_eop(o_dst_eop), .i_dst_full(i_dst_full), .i_dst_packets(i_dst_packets),
    .o_busy(o_busy), .o_pkt_cnt(o_pkt_cnt), .o_err(o_err)
  );

  initial clk_xbar = 1'b0;
  always #5 clk_xbar = ~clk_xbar;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Source memory: word k of the current packet; the size word carries the
  // length in its low bits with junk above to prove masking.
  logic [5:0]    cur_len;
  logic [7:0]    tag;
  int            exp_last;
  logic [OW-1:0] r1, r2;

  always @(posedge clk_xbar) begin
    r1 <= o_src_offset;
    r2 <= r1;
  end
  always_comb
    i_src_data = (r2 == OW'(SIZE_WORD)) ? {10'h2A5, cur_len} : {tag, 2'b00, r2};

  function automatic logic [DW-1:0] exp_word(input int k);
    if (k == SIZE_WORD) return {10'h2A5, cur_len};
    return {tag, 2'b00, 6'(k)};
  endfunction

  task automatic set_len(input int len);
    cur_len  = 6'(len);
    exp_last = (len + LEN_ADJ > 63) ? 63 : len + LEN_ADJ;
  endtask

  typedef struct packed {
    logic [NVC-1:0] vc;
    logic [OW-1:0]  off;
    logic [DW-1:0]  data;
    logic           eop;
    logic [31:0]    cyc;
  } enq_t;

  enq_t           sb[$];
  logic [NVC-1:0] gq[$];
  logic [NVC-1:0] cur_gnt;
  int cyc = 0, exp_off = 0, pkt_start = 0, pkt_done = 0, last_eop_cyc = 0;
  bit in_pkt = 0;

  // Monitor: check dequeues against the model, push the expected enqueue,
  // pop and compare when the destination side fires.
  always @(negedge clk_xbar) begin
    if (!rst_xbar_n) begin
      sb.delete();
      in_pkt = 0;
    end else begin
      cyc++;
      if (|o_src_deq) begin
        if (!in_pkt) begin
          in_pkt = 1; exp_off = 0; pkt_start++;
          if (gq.size() == 0) begin
            chk("grant_unexpected", 64'(o_src_deq), 64'd0);
            cur_gnt = o_src_deq;
          end else begin
            cur_gnt = gq.pop_front();
            chk("grant", 64'(o_src_deq), 64'(cur_gnt));
          end
          if (pkt_done > 0) chk("gap_len", 64'(cyc - last_eop_cyc - 1 >= GAP_CYC), 64'd1);
        end
        chk("src_offset", 64'(o_src_offset), 64'(exp_off));
        chk("src_eop", 64'(o_src_eop), 64'(exp_off == exp_last));
        sb.push_back('{vc: cur_gnt, off: OW'(exp_off), data: exp_word(exp_off),
                       eop: (exp_off == exp_last), cyc: 32'(cyc + RD_LAT + 1)});
        if (exp_off == exp_last) in_pkt = 0;
        exp_off++;
      end
      if (|o_dst_enq) begin
        if (sb.size() == 0) chk("enq_unexpected", 64'(o_dst_enq), 64'd0);
        else begin
          enq_t e;
          e = sb.pop_front();
          chk("enq_vc", 64'(o_dst_enq), 64'(e.vc));
          chk("enq_offset", 64'(o_dst_offset), 64'(e.off));
          chk("enq_data", 64'(o_dst_data), 64'(e.data));
          chk("enq_cycle", 64'(cyc), 64'(e.cyc));
          chk("enq_eop", 64'(o_dst_eop), 64'(e.eop));
          if (e.eop) begin pkt_done++; last_eop_cyc = cyc; end
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk_xbar);
    rst_xbar_n = 1'b0;
    gq.delete();
    i_dst_full = '0;
    #1;
    chk("reset_outputs", 64'({o_src_deq, o_src_offset, o_src_eop, o_dst_enq, o_dst_offset,
                              o_dst_data, o_dst_eop, o_busy, o_pkt_cnt, o_err}), 64'd0);
    repeat (2) @(negedge clk_xbar);
    rst_xbar_n = 1'b1;
  endtask

  task automatic wait_start(input int n, input string t);
    int k = 0;
    while (pkt_start < n && k < 3000) begin @(negedge clk_xbar); k++; end
    chk(t, 64'(pkt_start >= n), 64'd1);
  endtask

  task automatic wait_done(input int n, input string t);
    int k = 0;
    while (pkt_done < n && k < 3000) begin @(negedge clk_xbar); k++; end
    chk(t, 64'(pkt_done >= n), 64'd1);
    repeat (3) @(negedge clk_xbar);
  endtask

  initial begin
    int s0, d0;
    rst_xbar_n = 1'b1; i_src_empty = '1; i_dst_packets = '0; i_dst_full = '0;
    tag = 8'h11; set_len(2);

    // Single packet on VC1, length field 2 -> offsets 0..8.
    do_reset();
    i_src_empty = 3'b101; i_dst_packets = {3'd0, 3'd3, 3'd0};
    s0 = pkt_start; d0 = pkt_done; gq.push_back(3'b010);
    wait_start(s0 + 1, "t1_start");
    i_src_empty = '1;
    wait_done(d0 + 1, "t1_done");
    chk("t1_pkt_cnt", 64'(o_pkt_cnt), 64'd1);
    chk("t1_err", 64'(o_err), 64'd0);
    chk("t1_idle", 64'(o_busy), 64'd0);

    // All VCs eligible: four packets rotate VC0, VC1, VC2, VC0.
    do_reset();
    tag = 8'h5A; set_len(4);
    i_src_empty = '0; i_dst_packets = {3'd3, 3'd3, 3'd3};
    s0 = pkt_start; d0 = pkt_done;
    gq.push_back(3'b001); gq.push_back(3'b010); gq.push_back(3'b100); gq.push_back(3'b001);
    wait_start(s0 + 4, "t2_start");
    i_src_empty = '1;
    wait_done(d0 + 4, "t2_done");
    chk("t2_pkt_cnt", 64'(o_pkt_cnt), 64'd4);

    // VC0 has one free packet slot (< 2): VC2 is served, VC0 waits.
    do_reset();
    tag = 8'h3C; set_len(1);
    i_src_empty = 3'b010; i_dst_packets = {3'd3, 3'd0, 3'd1};
    s0 = pkt_start; d0 = pkt_done; gq.push_back(3'b100);
    wait_start(s0 + 1, "t3_start");
    i_src_empty = 3'b110;
    wait_done(d0 + 1, "t3_done");
    repeat (20) @(negedge clk_xbar);
    chk("t3_vc0_skipped", 64'(pkt_start - s0), 64'd1);
    gq.push_back(3'b001);
    i_dst_packets = {3'd3, 3'd0, 3'd2};
    wait_start(s0 + 2, "t3_vc0_start");
    i_src_empty = '1;
    wait_done(d0 + 2, "t3_vc0_done");
    chk("t3_pkt_cnt", 64'(o_pkt_cnt), 64'd2);

    // Length field 62 overflows: clamp to 63, 64 words, sticky error.
    do_reset();
    tag = 8'h77; set_len(62);
    i_src_empty = 3'b110; i_dst_packets = {3'd0, 3'd0, 3'd4};
    s0 = pkt_start; d0 = pkt_done; gq.push_back(3'b001);
    wait_start(s0 + 1, "t4_start");
    i_src_empty = '1;
    wait_done(d0 + 1, "t4_done");
    chk("t4_err", 64'(o_err), 64'd1);
    chk("t4_pkt_cnt", 64'(o_pkt_cnt), 64'd1);

    // Destination full pulsed during drain: error, packet still completes.
    do_reset();
    chk("t5_err_cleared", 64'(o_err), 64'd0);
    tag = 8'h24; set_len(2);
    i_src_empty = 3'b011; i_dst_packets = {3'd2, 3'd0, 3'd0};
    s0 = pkt_start; d0 = pkt_done; gq.push_back(3'b100);
    wait_start(s0 + 1, "t5_start");
    i_src_empty = '1;
    begin
      int k = 0;
      while (!(|o_dst_enq && o_dst_offset == 6'd6) && k < 200) begin @(negedge clk_xbar); k++; end
      chk("t5_saw_offset6", 64'(o_dst_offset), 64'd6);
      i_dst_full = 3'b100;
      @(negedge clk_xbar);
      i_dst_full = '0;
    end
    wait_done(d0 + 1, "t5_done");
    chk("t5_err", 64'(o_err), 64'd1);
    chk("t5_pkt_cnt", 64'(o_pkt_cnt), 64'd1);

    // Reset mid-COPY: outputs clear at once, next grant is VC0 again.
    do_reset();
    tag = 8'h66; set_len(3);
    i_src_empty = 3'b101; i_dst_packets = {3'd0, 3'd3, 3'd0};
    s0 = pkt_start; gq.push_back(3'b010);
    wait_start(s0 + 1, "t6_start");
    @(negedge clk_xbar);
    #2 rst_xbar_n = 1'b0;
    #1;
    chk("t6_async_clear", 64'({o_src_deq, o_src_offset, o_src_eop, o_dst_enq, o_dst_offset,
                               o_dst_data, o_dst_eop, o_busy, o_pkt_cnt, o_err}), 64'd0);
    gq.delete();
    i_src_empty = '0; i_dst_packets = {3'd3, 3'd3, 3'd3};
    repeat (2) @(negedge clk_xbar);
    s0 = pkt_start; d0 = pkt_done; gq.push_back(3'b001);
    rst_xbar_n = 1'b1;
    wait_start(s0 + 1, "t6_restart");
    i_src_empty = '1;
    wait_done(d0 + 1, "t6_done");
    chk("t6_pkt_cnt", 64'(o_pkt_cnt), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/xbglue_rr.md
Name: xbglue_rr

Overview:
- Parametrised successor to the two-port XBI glue. Moves whole packets from one XBI source port to one XBI destination port with no crossbar.
- Supports NVC virtual channels with round-robin arbitration, a configurable destination-space threshold, configurable source read latency and header length field.
- Adds a post-packet holdoff, a packet counter and a sticky protocol-error flag.
- Sits between a NI/mailbox XBI port and a link XBI port in point-to-point tiles.

Parameters:
NVC, 3, number of virtual channels
DW, 16, XBI data width
OW, 6, XBI word-offset width
PW, 3, width of each per-VC destination free-packet count
RD_LAT, 2, cycles from o_src_offset/o_src_deq to valid i_src_data
SIZE_WORD, 3, offset of the word holding the length field
LEN_ADJ, 6, last offset = length field [OW-1:0] + LEN_ADJ
MIN_PKTS, 2, destination VC eligible when free-packet count >= MIN_PKTS
GAP_CYC, 2, holdoff cycles after a packet before re-arbitration

Ports:
clk_xbar  in  1  clock
rst_xbar_n  in  1  asynchronous reset, active-low
o_src_deq  out  NVC  one-hot source dequeue strobe
o_src_offset  out  OW  source read offset
o_src_eop  out  1  source end of packet, with last dequeue
i_src_data  in  DW  source read data
i_src_empty  in  NVC  per-VC source empty
o_dst_enq  out  NVC  one-hot destination enqueue strobe
o_dst_offset  out  OW  destination write offset
o_dst_data  out  DW  destination write data
o_dst_eop  out  1  destination end of packet, with last enqueue
i_dst_full  in  NVC  per-VC destination full (checked only)
i_dst_packets  in  NVC*PW  per-VC free-packet counts, VC v at [v*PW +: PW]
o_busy  out  1  high when not IDLE
o_pkt_cnt  out  16  packets forwarded, wraps at 2^16
o_err  out  1  sticky protocol error

Behaviour:
- Reset:
  - All outputs 0. FSM goes to IDLE.
  - RR pointer = NVC-1, so VC0 wins first.
  - Reset mid-packet abandons the packet; no recovery.
- Input sampling:
  - i_src_empty and i_dst_packets are registered.
  - eligible[v] = ~empty_q[v] & (pkts_q[v] >= MIN_PKTS).
- Elaboration check: SIZE_WORD+RD_LAT < LEN_ADJ; otherwise fatal.
- FSM states: IDLE, COPY, DRAIN, GAP.
- IDLE:
  - If any VC is eligible, grant the first eligible VC after the RR pointer (wrapping).
  - Update the pointer to the granted VC, set deq_cnt=0 and last=all-ones, go to COPY.
- COPY:
  - Each cycle: o_src_deq = grant, o_src_offset = deq_cnt, then deq_cnt++.
  - These outputs are registered, so the first dequeue appears on the cycle after the IDLE->COPY transition.
  - When the returning word has offset SIZE_WORD: last = field + LEN_ADJ, computed in OW+1 bits.
  - If last exceeds 2^OW-1: clamp to 2^OW-1 and set o_err.
  - When deq_cnt == last: o_src_eop=1 with that dequeue, go to DRAIN.
- Return path:
  - Word for offset k arrives on i_src_data RD_LAT cycles after o_src_offset=k.
  - It is registered and driven as o_dst_enq=grant, o_dst_offset=k, o_dst_data=word one cycle later.
  - Tracked by an RD_LAT-deep valid/offset shift pipeline.
- DRAIN:
  - Keep enqueuing returning words.
  - On the enqueue with offset == last: o_dst_eop=1, o_pkt_cnt++, go to GAP.
- GAP: hold GAP_CYC cycles with all strobes 0, then go to IDLE. This lets source and destination status settle.
- o_err (sticky until reset) is set when:
  - length overflow, or
  - i_dst_full[grant] is seen while enqueuing.
  - On error the transfer still completes.
- Strobes o_src_deq, o_dst_enq, o_src_eop, o_dst_eop are 0 outside transfers. Offset and data hold their last value.
- Packet latency: first o_src_deq to last o_dst_enq = last + RD_LAT + 1 cycles.

Decomposition:
- Package xbi_pkg: FSM state encoding, XBI width defaults, packed-count slice helper.
- Sub-module xbglue_rr_arb: NVC-wide round-robin arbiter with request, pointer update enable, and one-hot grant.

Test Plan:
- Reset released, VC1 non-empty, packets_vc1=3, length field 2 (RD_LAT=2) -> dequeues offsets 0..8; enqueues 0..8 each 3 cycles later; o_dst_eop on offset 8; o_pkt_cnt=1.
- All VCs non-empty with space, 4 packets -> grants VC0, VC1, VC2, VC0; each separated by >= GAP_CYC idle cycles.
- VC0 packets_vc0=1, VC2 eligible -> VC2 served; VC0 skipped until count >= 2.
- Length field 62 (OW=6) -> last clamped to 63; o_err=1; 64 words moved.
- i_dst_full[grant] pulsed mid-DRAIN -> o_err=1; packet completes with o_dst_eop.
- rst_xbar_n asserted mid-COPY -> all outputs 0 immediately; next arbitration starts from VC0.
